// File: rtl/writeback_arbiter.sv
// Merges execute results and buffered load returns into one register-file write port,
// tracks pending loads for issue stalls. Optional `WRITEBACK_BYPASS_EN` lets a return skip the FIFO.
module writeback_arbiter #(
  parameter int unsigned DATABITWIDTH    = 16,
  parameter int unsigned REGISTERCOUNT   = 16,
  parameter int unsigned REGADDRBITWIDTH = 4,
  parameter int unsigned LOADQDEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       sync_rst_n,
  input  logic                       clk_en,
  input  logic                       ExecWriteEn,
  input  logic [REGADDRBITWIDTH-1:0] ExecRegAddr,
  input  logic [DATABITWIDTH-1:0]    ExecData,
  input  logic                       LoadIssueEn,
  input  logic [REGADDRBITWIDTH-1:0] LoadIssueAddr,
  input  logic                       LoadRetValid,
  output logic                       LoadRetReady,
  input  logic [REGADDRBITWIDTH-1:0] LoadRetRegAddr,
  input  logic [DATABITWIDTH-1:0]    LoadRetData,
  input  logic                       RegAReadEn,
  input  logic                       RegBReadEn,
  input  logic [REGADDRBITWIDTH-1:0] RegAAddr,
  input  logic [REGADDRBITWIDTH-1:0] RegBAddr,
  output logic                       StallA,
  output logic                       StallB,
  output logic                       Forward1Valid,
  output logic [REGADDRBITWIDTH-1:0] Forward1RegAddr,
  output logic [DATABITWIDTH-1:0]    Forward1Data
);

  localparam int unsigned PtrW = $clog2(LOADQDEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCount = CntW'(LOADQDEPTH);

  logic [REGADDRBITWIDTH-1:0] qAddr [LOADQDEPTH];
  logic [DATABITWIDTH-1:0]    qData [LOADQDEPTH];
  logic [PtrW-1:0]            rdPtr, wrPtr;
  logic [CntW-1:0]            count;
  logic [REGISTERCOUNT-1:0]   pending, pendingNext;

  logic                       qEmpty, retFire, bypassTake, push, pop;
  logic                       wbValid, wbFromLoad;
  logic [REGADDRBITWIDTH-1:0] wbAddr;
  logic [DATABITWIDTH-1:0]    wbData;

  assign LoadRetReady = clk_en && (count != FullCount);
  assign StallA       = RegAReadEn && pending[RegAAddr];
  assign StallB       = RegBReadEn && pending[RegBAddr];

  always_comb begin
    qEmpty  = (count == '0);
    retFire = LoadRetValid && LoadRetReady;
`ifdef WRITEBACK_BYPASS_EN
    bypassTake = retFire && qEmpty && !ExecWriteEn;
`else
    bypassTake = 1'b0;
`endif
    push = retFire && !bypassTake;
    pop  = clk_en && !ExecWriteEn && !qEmpty;

    // Address/data hold when nothing wins; only the valid bit drops.
    wbValid    = 1'b0;
    wbFromLoad = 1'b0;
    wbAddr     = Forward1RegAddr;
    wbData     = Forward1Data;
    if (ExecWriteEn) begin
      wbValid = 1'b1;
      wbAddr  = ExecRegAddr;
      wbData  = ExecData;
    end else if (!qEmpty) begin
      wbValid    = 1'b1;
      wbFromLoad = 1'b1;
      wbAddr     = qAddr[rdPtr];
      wbData     = qData[rdPtr];
    end else if (bypassTake) begin
      wbValid    = 1'b1;
      wbFromLoad = 1'b1;
      wbAddr     = LoadRetRegAddr;
      wbData     = LoadRetData;
    end

    // Clear before set so a same-cycle re-issue keeps the register pending.
    pendingNext = pending;
    if (wbFromLoad) pendingNext[wbAddr] = 1'b0;
    if (LoadIssueEn) pendingNext[LoadIssueAddr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!sync_rst_n) begin
      Forward1Valid   <= 1'b0;
      Forward1RegAddr <= '0;
      Forward1Data    <= '0;
      rdPtr           <= '0;
      wrPtr           <= '0;
      count           <= '0;
      pending         <= '0;
    end else if (clk_en) begin
      Forward1Valid   <= wbValid;
      Forward1RegAddr <= wbAddr;
      Forward1Data    <= wbData;
      pending         <= pendingNext;
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      count <= count + CntW'(push) - CntW'(pop);
    end
  end

  // Storage needs no reset; the count alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      qAddr[wrPtr] <= LoadRetRegAddr;
      qData[wrPtr] <= LoadRetData;
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: reference model feeds an expected-write queue.
module tb_writeback_arbiter;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 4;
  localparam int unsigned QD = 4;

  logic          clk;
  logic          sync_rst_n;
  logic          clk_en;
  logic          ExecWriteEn;
  logic [AW-1:0] ExecRegAddr;
  logic [DW-1:0] ExecData;
  logic          LoadIssueEn;
  logic [AW-1:0] LoadIssueAddr;
  logic          LoadRetValid;
  logic          LoadRetReady;
  logic [AW-1:0] LoadRetRegAddr;
  logic [DW-1:0] LoadRetData;
  logic          RegAReadEn, RegBReadEn;
  logic [AW-1:0] RegAAddr, RegBAddr;
  logic          StallA, StallB;
  logic          Forward1Valid;
  logic [AW-1:0] Forward1RegAddr;
  logic [DW-1:0] Forward1Data;

  writeback_arbiter #(
    .DATABITWIDTH   (DW),
    .REGISTERCOUNT  (16),
    .REGADDRBITWIDTH(AW),
    .LOADQDEPTH     (QD)
  ) dut (
    .clk            (clk),
    .sync_rst_n     (sync_rst_n),
    .clk_en         (clk_en),
    .ExecWriteEn    (ExecWriteEn),
    .ExecRegAddr    (ExecRegAddr),
    .ExecData       (ExecData),
    .LoadIssueEn    (LoadIssueEn),
    .LoadIssueAddr  (LoadIssueAddr),
    .LoadRetValid   (LoadRetValid),
    .LoadRetReady   (LoadRetReady),
    .LoadRetRegAddr (LoadRetRegAddr),
    .LoadRetData    (LoadRetData),
    .RegAReadEn     (RegAReadEn),
    .RegBReadEn     (RegBReadEn),
    .RegAAddr       (RegAAddr),
    .RegBAddr       (RegBAddr),
    .StallA         (StallA),
    .StallB         (StallB),
    .Forward1Valid  (Forward1Valid),
    .Forward1RegAddr(Forward1RegAddr),
    .Forward1Data   (Forward1Data)
  );

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } WbEntry;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } RetEntry;

  int nChecks = 0;
  int nFail   = 0;

  WbEntry  expQ[$];
  RetEntry modelQ[$];
  WbEntry  lastExp;
  logic [15:0] modelPending;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, check combinational outputs, advance model, then check writeback.
  task automatic step(input logic ce, input logic ex, input logic [AW-1:0] ea,
                      input logic [DW-1:0] ed, input logic rv, input logic [AW-1:0] ra,
                      input logic [DW-1:0] rd, input logic li, input logic [AW-1:0] la);
    WbEntry  e;
    WbEntry  got;
    RetEntry r;
    logic    acc;
    logic    fromLoad;
    clk_en = ce; ExecWriteEn = ex; ExecRegAddr = ea; ExecData = ed;
    LoadRetValid = rv; LoadRetRegAddr = ra; LoadRetData = rd;
    LoadIssueEn = li; LoadIssueAddr = la;
    #1;
    checkVal("ready", 32'(LoadRetReady), 32'(ce && (modelQ.size() < QD)));
    checkVal("stallA", 32'(StallA), 32'(RegAReadEn && modelPending[RegAAddr]));
    checkVal("stallB", 32'(StallB), 32'(RegBReadEn && modelPending[RegBAddr]));
    acc = rv && ce && (modelQ.size() < QD);
    if (ce) begin
      e = lastExp;
      e.valid = 1'b0;
      fromLoad = 1'b0;
      if (ex) begin
        e = '{valid: 1'b1, addr: ea, data: ed};
      end else if (modelQ.size() != 0) begin
        r = modelQ.pop_front();
        e = '{valid: 1'b1, addr: r.addr, data: r.data};
        fromLoad = 1'b1;
      end
`ifdef WRITEBACK_BYPASS_EN
      else if (acc) begin
        e = '{valid: 1'b1, addr: ra, data: rd};
        fromLoad = 1'b1;
        acc = 1'b0;
      end
`endif
      if (acc) modelQ.push_back('{addr: ra, data: rd});
      if (fromLoad) modelPending[e.addr] = 1'b0;
      if (li) modelPending[la] = 1'b1;
      lastExp = e;
    end
    expQ.push_back(lastExp);
    @(posedge clk);
    #1;
    got = expQ.pop_front();
    checkVal("fwdValid", 32'(Forward1Valid), 32'(got.valid));
    if (got.valid) begin
      checkVal("fwdAddr", 32'(Forward1RegAddr), 32'(got.addr));
      checkVal("fwdData", 32'(Forward1Data), 32'(got.data));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic applyReset(input logic ce);
    sync_rst_n = 1'b0; clk_en = ce;
    ExecWriteEn = 1'b1; ExecRegAddr = 4'hF; ExecData = 16'hDEAD;
    LoadIssueEn = 1'b1; LoadIssueAddr = 4'hC;
    LoadRetValid = 1'b1; LoadRetRegAddr = 4'hE; LoadRetData = 16'hCAFE;
    RegAReadEn = 1'b1; RegAAddr = 4'hC; RegBReadEn = 1'b1; RegBAddr = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    checkVal("rstValid", 32'(Forward1Valid), 32'd0);
    checkVal("rstAddr", 32'(Forward1RegAddr), 32'd0);
    checkVal("rstData", 32'(Forward1Data), 32'd0);
    checkVal("rstStallA", 32'(StallA), 32'd0);
    checkVal("rstStallB", 32'(StallB), 32'd0);
    checkVal("rstReady", 32'(LoadRetReady), 32'(ce));
    sync_rst_n = 1'b1;
    modelQ.delete();
    expQ.delete();
    modelPending = '0;
    lastExp = '0;
  endtask

  initial begin
    applyReset(1'b1);
    idle(2);

    // Execute only.
    step(1'b1, 1'b1, 4'd3, 16'hBEEF, 1'b0, '0, '0, 1'b0, '0);
    idle(2);

    // Load return competing with three execute writes.
    step(1'b1, 1'b1, 4'd2, 16'h1111, 1'b1, 4'd5, 16'h1234, 1'b0, '0);
    step(1'b1, 1'b1, 4'd2, 16'h2222, 1'b0, '0, '0, 1'b0, '0);
    step(1'b1, 1'b1, 4'd2, 16'h3333, 1'b0, '0, '0, 1'b0, '0);
    idle(2);

    // Fill the FIFO behind execute writes; fifth offer is refused.
    for (int i = 0; i < 5; i++)
      step(1'b1, 1'b1, 4'd1, 16'(16'h0100 + i), 1'b1, 4'(8 + i), 16'(16'hA000 + i), 1'b0, '0);
    step(1'b1, 1'b0, '0, '0, 1'b1, 4'd13, 16'hAAAA, 1'b0, '0);
    idle(6);

    // Scoreboard: set, stall, clear on writeback.
    RegAAddr = 4'd7; RegBAddr = 4'd6;
    step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 4'd7);
    idle(1);
    step(1'b1, 1'b0, '0, '0, 1'b1, 4'd7, 16'h7777, 1'b0, '0);
    idle(2);
    // Re-issue to 7 on the same cycle its load writes back.
    step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 4'd7);
    step(1'b1, 1'b1, 4'd3, 16'h0033, 1'b1, 4'd7, 16'h7070, 1'b0, '0);
    step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 4'd7);
    idle(1);
    RegAReadEn = 1'b0;
    idle(1);
    RegAReadEn = 1'b1;
    step(1'b1, 1'b0, '0, '0, 1'b1, 4'd7, 16'h7171, 1'b0, '0);
    idle(2);

    // Single return into an empty FIFO (latency depends on bypass).
    step(1'b1, 1'b0, '0, '0, 1'b1, 4'd9, 16'h9999, 1'b0, '0);
    idle(2);

    // Global stall mid-sequence.
    step(1'b1, 1'b1, 4'd4, 16'h4444, 1'b1, 4'd10, 16'hB0B0, 1'b0, '0);
    step(1'b0, 1'b1, 4'd6, 16'h6666, 1'b1, 4'd11, 16'hB1B1, 1'b1, 4'd11);
    step(1'b0, 1'b0, '0, '0, 1'b1, 4'd12, 16'hB2B2, 1'b0, '0);
    step(1'b1, 1'b1, 4'd5, 16'h5555, 1'b1, 4'd11, 16'hB3B3, 1'b0, '0);
    idle(3);

    // Reset mid-operation with clk_en low discards queued returns and pending bits.
    step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 4'd7);
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, 4'd2, 16'(16'h0200 + i), 1'b1, 4'd7, 16'(16'hC000 + i), 1'b0, '0);
    applyReset(1'b0);
    RegAAddr = 4'd7; RegBAddr = 4'd7;
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/writeback_arbiter.md
# writeback_arbiter

Merges the two register-file write sources (single-cycle execute results and asynchronous load/IO returns) into the single register-file write port. The same registered write is published as the late forwarding source (`Forward1Valid/Data/RegAddr`) consumed by the operand forwarding stage. Load returns are buffered in a small FIFO. A per-register pending-load scoreboard produces issue stalls for operands whose load has not yet written back.

## Interface
Parameters:
- `DATABITWIDTH`, 16, data width
- `REGISTERCOUNT`, 16, number of architectural registers
- `REGADDRBITWIDTH`, 4, register address width
- `LOADQDEPTH`, 4, load-return FIFO depth, power of two, ≥2

Ports:
- `clk`  in  1  clock; all state updates on its rising edge
- `sync_rst_n`  in  1  synchronous active-low reset; independent of `clk_en`
- `clk_en`  in  1  global stall; state holds when low
- `ExecWriteEn`  in  1  execute result valid this cycle
- `ExecRegAddr`  in  REGADDRBITWIDTH  execute destination
- `ExecData`  in  DATABITWIDTH  execute result
- `LoadIssueEn`  in  1  a load to `LoadIssueAddr` issues this cycle
- `LoadIssueAddr`  in  REGADDRBITWIDTH  load destination
- `LoadRetValid`  in  1  load return offered
- `LoadRetReady`  out  1  FIFO can accept
- `LoadRetRegAddr`  in  REGADDRBITWIDTH  returning load destination
- `LoadRetData`  in  DATABITWIDTH  returning load data
- `RegAReadEn`, `RegBReadEn`  in  1  operand read enables at issue
- `RegAAddr`, `RegBAddr`  in  REGADDRBITWIDTH  operand addresses
- `StallA`, `StallB`  out  1  operand targets a pending load
- `Forward1Valid`  out  1  registered write valid; also register-file write enable
- `Forward1RegAddr`  out  REGADDRBITWIDTH  registered write address
- `Forward1Data`  out  DATABITWIDTH  registered write data

## Operation
- Transfer: load return accepted when `LoadRetValid && LoadRetReady`.
- `LoadRetReady = clk_en && (count != LOADQDEPTH)`. Full blocks push even if a pop occurs the same cycle.
- FIFO: circular, `log2(LOADQDEPTH)`-bit read/write pointers wrap naturally. Count width is `log2(LOADQDEPTH)+1`.
- Arbitration, evaluated each `clk_en` cycle:
  - `ExecWriteEn` high: the execute write wins. FIFO head holds.
  - Otherwise, FIFO non-empty: the head pops.
  - Otherwise: `Forward1Valid` is cleared.
- Writeback register: the winning source loads `Forward1Valid/RegAddr/Data`. `Forward1Valid` is low if no source.
- Scoreboard: `Pending[REGISTERCOUNT]`.
  - Set on `LoadIssueEn` for `LoadIssueAddr`.
  - Cleared when a load-sourced entry is loaded into the writeback register for that address.
  - Same-address set and clear in one cycle: set wins.
  - An execute write does not touch `Pending`.
- Stalls, combinational:
  - `StallA = RegAReadEn && Pending[RegAAddr]`
  - `StallB = RegBReadEn && Pending[RegBAddr]`
- Ordering of same-register execute and load writes is the issue logic's responsibility, via the stalls.

## Timing
- Reset values (`sync_rst_n` low at a clock edge, regardless of `clk_en`):
  - `Forward1Valid`=0, `Forward1RegAddr`=0, `Forward1Data`=0
  - pointers=0, count=0, `Pending`=0
  - Hence `StallA/B`=0, and `LoadRetReady` = `clk_en`.
- Reset mid-operation discards FIFO contents and pending bits. In-flight returns must be squashed by the memory side.
- Execute write latency: 1 cycle. `ExecWriteEn` at edge N gives `Forward1Valid` from N+1 for one cycle.
- Load return latency into an empty FIFO with no execute write: 2 cycles (see Configuration). Each execute-write cycle adds 1.
- Empty FIFO with push and no execute write: the pop occurs the following cycle.
- Simultaneous push and pop when not full: count unchanged.
- `clk_en` low: no push, no pop, no writeback or scoreboard change. `Forward1*` holds its value. The register file must gate its write with `clk_en`.

## Configuration
- `WRITEBACK_BYPASS_EN` defined: when the FIFO is empty, `ExecWriteEn` is low and a transfer occurs, the return loads the writeback register directly without enqueuing. Latency is 1 cycle, and the scoreboard clears the same cycle.
- Undefined: every return enqueues. Minimum latency is 2 cycles.

## Test plan
- Reset: hold `sync_rst_n`=0 with garbage inputs → all outputs 0 except `LoadRetReady`=1 with `clk_en`=1. After release, FIFO is empty.
- Execute only: `ExecWriteEn`=1, addr 3, data 0xBEEF → next cycle `Forward1Valid`=1, addr 3, data 0xBEEF; following cycle valid=0.
- Conflict: load return (addr 5, 0x1234) into an empty FIFO while `ExecWriteEn` is held for 3 cycles (addr 2) → three writes to reg 2, then reg 5 with 0x1234 at the 4th output cycle.
- Full: hold `ExecWriteEn`=1 and push 4 returns → `LoadRetReady`=0 on the 5th offer. Drop `ExecWriteEn` → 4 writes in FIFO order, ready re-asserts after the first pop.
- Scoreboard: `LoadIssueEn` addr 7 → `StallA`=1 for `RegAAddr`=7, `StallB`=0 for 6. Clears the cycle reg 7 loads into writeback. A same-cycle re-issue to 7 keeps it set.
- Bypass: empty FIFO, single return → `Forward1Valid` 1 cycle later with the macro defined, 2 cycles later without it. `clk_en`=0 for 2 cycles mid-sequence → outputs frozen, order preserved.
